// File: rtl/traffic_burst_scheduler_gmii.sv
// Burst scheduler for a GMII traffic generator: N bursts of M frames with a
// programmable idle gap, counting frame starts observed on gmii_en.
module traffic_burst_scheduler_gmii #(
  parameter int unsigned FRAMES_W = 32,
  parameter int unsigned BURSTS_W = 16,
  parameter int unsigned GAP_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [FRAMES_W-1:0] burst_frames,
  input  logic [BURSTS_W-1:0] burst_count,
  input  logic [GAP_W-1:0]    gap_cycles,
  input  logic                gmii_en,
  output logic                gen_enable,
  output logic                busy,
  output logic                done,
  output logic [BURSTS_W-1:0] bursts_done,
  output logic [63:0]         frames_total
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;

  state_t              state, state_nx;
  logic                gmii_en_d;
  logic                sof;
  logic [FRAMES_W-1:0] frames_cfg, frame_cnt, frame_cnt_inc;
  logic [BURSTS_W-1:0] bursts_cfg, bursts_inc;
  logic [GAP_W-1:0]    gap_cfg, gap_cnt;
  logic                abort, partial;
  logic                accept_start, burst_hit, last_burst;
  logic                gen_enable_nx, busy_nx, done_nx;

  assign sof           = gmii_en & ~gmii_en_d;
  assign frame_cnt_inc = frame_cnt + FRAMES_W'(1);
  assign bursts_inc    = bursts_done + BURSTS_W'(1);
  // stop has priority over a simultaneous start
  assign accept_start  = (state == IDLE) && start && !stop;
  assign burst_hit     = (state == RUN) && sof && (frame_cnt_inc == frames_cfg);
  assign last_burst    = (bursts_cfg != '0) && (bursts_inc == bursts_cfg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gmii_en_d  <= 1'b0;
    end else begin
      state      <= state_nx;
      gen_enable <= gen_enable_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      gmii_en_d  <= gmii_en;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept_start && (burst_frames != '0)) state_nx = RUN;
      end
      RUN: begin
        if (stop || burst_hit) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!gmii_en) begin
          if (abort || stop || last_burst) state_nx = IDLE;
          else if (gap_cfg == '0)          state_nx = RUN;
          else                             state_nx = GAP;
        end
      end
      GAP: begin
        if (stop)                        state_nx = IDLE;
        else if (gap_cnt == GAP_W'(1))   state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gen_enable_nx = (state_nx == RUN);
    busy_nx       = (state_nx != IDLE);
    done_nx       = ((state != IDLE) && (state_nx == IDLE)) ||
                    (accept_start && (burst_frames == '0));
  end

  // partial marks a burst cut short by stop, so its DRAIN exit is not counted
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_cfg   <= '0;
      bursts_cfg   <= '0;
      gap_cfg      <= '0;
      frame_cnt    <= '0;
      gap_cnt      <= '0;
      bursts_done  <= '0;
      frames_total <= '0;
      abort        <= 1'b0;
      partial      <= 1'b0;
    end else if (accept_start) begin
      frames_cfg   <= burst_frames;
      bursts_cfg   <= burst_count;
      gap_cfg      <= gap_cycles;
      frame_cnt    <= '0;
      bursts_done  <= '0;
      frames_total <= '0;
      abort        <= 1'b0;
      partial      <= 1'b0;
    end else begin
      if ((state != IDLE) && sof) frames_total <= frames_total + 64'd1;
      case (state)
        RUN: begin
          if (sof) frame_cnt <= frame_cnt_inc;
          if (stop) begin
            abort   <= 1'b1;
            partial <= !burst_hit;
          end
        end
        DRAIN: begin
          if (stop) abort <= 1'b1;
          if (!gmii_en) begin
            if (!partial) bursts_done <= bursts_inc;
            frame_cnt <= '0;
            gap_cnt   <= gap_cfg;
          end
        end
        GAP: gap_cnt <= gap_cnt - GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_burst_scheduler_gmii.sv
// Bench for traffic_burst_scheduler_gmii: generator model plus a done-pulse
// scoreboard holding the expected bursts_done / frames_total per schedule.
`timescale 1ns/1ps
module tb_traffic_burst_scheduler_gmii;
  localparam int unsigned FRAMES_W = 32;
  localparam int unsigned BURSTS_W = 16;
  localparam int unsigned GAP_W    = 32;

  logic                clk = 1'b0;
  logic                rst, start, stop, gmii_en;
  logic [FRAMES_W-1:0] burst_frames;
  logic [BURSTS_W-1:0] burst_count;
  logic [GAP_W-1:0]    gap_cycles;
  logic                gen_enable, busy, done;
  logic [BURSTS_W-1:0] bursts_done;
  logic [63:0]         frames_total;

  traffic_burst_scheduler_gmii #(.FRAMES_W(FRAMES_W), .BURSTS_W(BURSTS_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .burst_frames(burst_frames), .burst_count(burst_count), .gap_cycles(gap_cycles),
    .gmii_en(gmii_en), .gen_enable(gen_enable), .busy(busy), .done(done),
    .bursts_done(bursts_done), .frames_total(frames_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BURSTS_W-1:0] bursts;
    logic [63:0]         frames;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  // Generator model: 72-cycle frames, 12-cycle IFG, starts a frame only when
  // gen_enable was high in the preceding cycle (or when kicked by the bench).
  bit          kick = 1'b0;
  bit          in_frame = 1'b0;
  int unsigned frame_pos = 0;
  int unsigned ifg = 0;
  int unsigned cyc = 0;
  int unsigned sof_log[$];
  int unsigned eof_log[$];

  task automatic gen_model();
    logic ge_s;
    forever begin
      @(negedge clk);
      ge_s = gen_enable;
      @(posedge clk);
      #1;
      cyc++;
      if (in_frame) begin
        frame_pos++;
        if (frame_pos == 72) begin
          in_frame = 1'b0;
          gmii_en  = 1'b0;
          ifg      = 12;
          eof_log.push_back(cyc);
        end
      end else if (ifg != 0) begin
        ifg--;
      end else if (kick || ge_s === 1'b1) begin
        in_frame  = 1'b1;
        frame_pos = 0;
        gmii_en   = 1'b1;
        kick      = 1'b0;
        sof_log.push_back(cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && done === 1'b1) begin
      done_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 want no pulse at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (bursts_done !== e.bursts || frames_total !== e.frames) begin
          errors++;
          $display("FAIL done_counters: got bursts_done=%0d frames_total=%0d want %0d %0d",
                   bursts_done, frames_total, e.bursts, e.frames);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    sof_log.delete();
    eof_log.delete();
  endtask

  task automatic pulse_start(input int unsigned f, input int unsigned c, input int unsigned g);
    burst_frames = FRAMES_W'(f);
    burst_count  = BURSTS_W'(c);
    gap_cycles   = GAP_W'(g);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  function automatic bit cond_met(input int kind, input int unsigned n);
    case (kind)
      0: return sof_log.size() >= n;
      1: return eof_log.size() >= n;
      2: return done === 1'b1;
      3: return !in_frame && ifg == 0;
      default: return in_frame && frame_pos >= 5 && frame_pos <= 40;
    endcase
  endfunction

  // kind: 0 sof count, 1 eof count, 2 done, 3 generator idle, 4 mid-frame
  task automatic wait_for(input int kind, input int unsigned n, input int unsigned limit, input string name);
    int unsigned cnt = 0;
    while (!cond_met(kind, n)) begin
      if (cnt == limit) begin
        checks++;
        errors++;
        $display("FAIL %s: got timeout after %0d cycles want event", name, limit);
        return;
      end
      cnt++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({gen_enable, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000", {gen_enable, busy, done});
    end
    checks++;
    if (bursts_done !== '0 || frames_total !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d %0d want 0 0", bursts_done, frames_total);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_normal();
    int d0 = done_seen;
    clear_logs();
    sb.push_back('{bursts: 16'd2, frames: 64'd6});
    pulse_start(3, 2, 100);
    checks++;
    if (gen_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: got en=%b busy=%b want 1 1", gen_enable, busy);
    end
    wait_for(0, 3, 400, "burst1_sofs");
    step();
    checks++;
    if (gen_enable !== 1'b0 || frames_total !== 64'd3) begin
      errors++;
      $display("FAIL burst_end: got en=%b frames=%0d want 0 3", gen_enable, frames_total);
    end
    wait_for(2, 0, 3000, "normal_done");
    repeat (5) step();
    checks++;
    if (sof_log.size() != 6) begin
      errors++;
      $display("FAIL normal_sofs: got %0d want 6", sof_log.size());
    end
    checks++;
    if (sof_log.size() < 4 || eof_log.size() < 3) begin
      errors++;
      $display("FAIL normal_gap: got too few frames want gap measurement");
    end else if (sof_log[3] - eof_log[2] < 100) begin
      errors++;
      $display("FAIL normal_gap: got %0d want >= 100", sof_log[3] - eof_log[2]);
    end
    checks++;
    if (done_seen - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL normal_done_count: got %0d busy=%b want 1 0", done_seen - d0, busy);
    end
  endtask

  task automatic test_zero_gap_infinite();
    int unsigned n;
    clear_logs();
    pulse_start(4, 0, 0);
    wait_for(1, 4, 600, "inf_first_burst");
    checks++;
    if (gen_enable !== 1'b0) begin
      errors++;
      $display("FAIL inf_drain_en: got %b want 0", gen_enable);
    end
    step();
    checks++;
    if (gen_enable !== 1'b1 || bursts_done !== 16'd1) begin
      errors++;
      $display("FAIL inf_reenable: got en=%b bursts=%0d want 1 1", gen_enable, bursts_done);
    end
    repeat (1000) step();
    wait_for(4, 0, 200, "inf_midframe");
    n = sof_log.size();
    sb.push_back('{bursts: BURSTS_W'(n / 4), frames: 64'(n)});
    pulse_stop();
    wait_for(2, 0, 300, "inf_done");
    repeat (20) step();
    checks++;
    if (sof_log.size() != n || busy !== 1'b0 || gen_enable !== 1'b0) begin
      errors++;
      $display("FAIL inf_after_stop: got sofs=%0d busy=%b en=%b want %0d 0 0",
               sof_log.size(), busy, gen_enable, n);
    end
  endtask

  task automatic test_stop_gap();
    clear_logs();
    pulse_start(1, 3, 500);
    wait_for(1, 1, 300, "gap_first_eof");
    step();
    repeat (10) step();
    sb.push_back('{bursts: 16'd1, frames: 64'd1});
    pulse_stop();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || gen_enable !== 1'b0) begin
      errors++;
      $display("FAIL gap_stop: got busy=%b done=%b en=%b want 0 1 0", busy, done, gen_enable);
    end
    repeat (600) step();
    checks++;
    if (sof_log.size() != 1) begin
      errors++;
      $display("FAIL gap_no_more_sof: got %0d want 1", sof_log.size());
    end
  endtask

  task automatic test_degenerate();
    int d0 = done_seen;
    bit saw_en = 1'b0;
    clear_logs();
    sb.push_back('{bursts: 16'd0, frames: 64'd0});
    pulse_start(0, 5, 7);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gen_enable !== 1'b0) begin
      errors++;
      $display("FAIL empty_start: got done=%b busy=%b en=%b want 1 0 0", done, busy, gen_enable);
    end
    repeat (200) begin
      step();
      if (gen_enable !== 1'b0) saw_en = 1'b1;
    end
    checks++;
    if (saw_en || sof_log.size() != 0 || done_seen - d0 != 1) begin
      errors++;
      $display("FAIL empty_quiet: got en_seen=%b sofs=%0d dones=%0d want 0 0 1",
               saw_en, sof_log.size(), done_seen - d0);
    end
  endtask

  task automatic test_start_edges();
    wait_for(3, 0, 200, "edge_gen_idle");
    kick = 1'b1;
    step();
    clear_logs();
    sb.push_back('{bursts: 16'd1, frames: 64'd2});
    pulse_start(2, 1, 0);
    repeat (20) step();
    checks++;
    if (frames_total !== 64'd0 || gen_enable !== 1'b1) begin
      errors++;
      $display("FAIL inflight_frame: got frames=%0d en=%b want 0 1", frames_total, gen_enable);
    end
    pulse_start(5, 9, 3);
    wait_for(2, 0, 800, "edge_done");
    repeat (5) step();
    checks++;
    if (sof_log.size() != 2) begin
      errors++;
      $display("FAIL restart_ignored: got sofs=%0d want 2", sof_log.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_logs();
    pulse_start(3, 0, 0);
    wait_for(0, 1, 200, "rstmid_sof");
    repeat (3) step();
    d0 = done_seen;
    rst = 1'b1;
    step();
    checks++;
    if ({gen_enable, busy, done} !== 3'b000 || bursts_done !== '0 || frames_total !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid: got en=%b busy=%b done=%b bursts=%0d frames=%0d want all 0",
               gen_enable, busy, done, bursts_done, frames_total);
    end
    rst = 1'b0;
    wait_for(3, 0, 200, "rstmid_gen_idle");
    checks++;
    if (done_seen != d0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d pulses want 0", done_seen - d0);
    end
    clear_logs();
    sb.push_back('{bursts: 16'd1, frames: 64'd3});
    pulse_start(3, 1, 0);
    checks++;
    if (gen_enable !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_start: got en=%b busy=%b want 1 1", gen_enable, busy);
    end
    wait_for(2, 0, 1000, "post_reset_done");
    repeat (3) step();
    checks++;
    if (sof_log.size() != 3) begin
      errors++;
      $display("FAIL post_reset_sofs: got %0d want 3", sof_log.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; gmii_en = 1'b0;
    burst_frames = '0; burst_count = '0; gap_cycles = '0;
    fork
      gen_model();
    join_none
    test_reset();
    test_normal();
    test_zero_gap_infinite();
    test_stop_gap();
    test_degenerate();
    test_start_edges();
    test_reset_mid();
    repeat (5) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/traffic_burst_scheduler_gmii.md
# traffic_burst_scheduler_gmii

Burst controller that sequences a GMII traffic generator into N bursts of M frames, separated by a programmable idle gap. It drives the generator's enable and monitors the generator's `gmii_en` output to count frame starts. It sits between the CPU register block and `traffic_generator_gmii`, and replaces continuous-run mode when bursty test traffic is required.

## Interface
- `FRAMES_W`, 32: width of the frames-per-burst setting.
- `BURSTS_W`, 16: width of the burst-count setting and the `bursts_done` counter.
- `GAP_W`, 32: width of the inter-burst gap setting, in clk cycles.
- `clk`  in  1  single clock for the whole block (GMII clock domain).
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse; latches the config and begins the schedule.
- `stop`  in  1  one-cycle pulse; aborts the schedule at the next frame boundary.
- `burst_frames`  in  FRAMES_W  frames per burst; 0 means an empty schedule.
- `burst_count`  in  BURSTS_W  number of bursts; 0 means run forever.
- `gap_cycles`  in  GAP_W  idle clk cycles between the end of one burst and the re-enable.
- `gmii_en`  in  1  generator GMII enable, monitored only.
- `gen_enable`  out  1  registered enable to the generator.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the schedule completes or is aborted.
- `bursts_done`  out  BURSTS_W  bursts fully completed since the last start.
- `frames_total`  out  64  frame starts observed since the last start.

## Operation
- **States:**
  - IDLE: `gen_enable` = 0.
  - RUN: `gen_enable` = 1.
  - DRAIN: `gen_enable` = 0; waits for the current frame to end.
  - GAP: `gen_enable` = 0; counts down the gap.
- **Frame-start detect:** `sof` = `gmii_en` & ~`gmii_en_d`. `gmii_en_d` is registered every cycle, so a frame already in flight at start is not counted.
- **start in IDLE:**
  - Latches `burst_frames`, `burst_count` and `gap_cycles`.
  - Clears `bursts_done`, `frames_total` and the per-burst frame counter.
  - If `burst_frames` = 0: pulse `done` and stay in IDLE.
  - Otherwise go to RUN.
- **start while busy:** ignored. Config inputs are ignored except at an accepted start.
- **RUN:**
  - Each `sof` increments the per-burst counter and `frames_total`.
  - On the `sof` that makes the per-burst count equal the latched `burst_frames`, go to DRAIN.
- **DRAIN:** on the first cycle `gmii_en` = 0:
  - Increment `bursts_done` and clear the per-burst counter.
  - If `burst_count` != 0 and the incremented `bursts_done` = `burst_count`: go to IDLE and pulse `done`.
  - Else if `gap_cycles` = 0: go to RUN.
  - Else load the gap counter with `gap_cycles` and go to GAP.
- **GAP:** decrement the counter each cycle; on the cycle it reaches 1, go to RUN.
- **stop:**
  - In RUN: go to DRAIN with an abort flag set; on DRAIN exit go to IDLE and pulse `done`. `bursts_done` is not incremented for the partial burst.
  - In DRAIN: sets the abort flag.
  - In GAP: go to IDLE immediately and pulse `done`.
  - In IDLE: ignored. If start and stop occur in the same cycle in IDLE, stop wins.
- **sof in DRAIN or GAP** (generator contract violation): still counted in `frames_total`, not in the per-burst counter.
- **Wrap-around:**
  - `frames_total` wraps at 2^64.
  - `bursts_done` wraps at 2^BURSTS_W in infinite mode (`burst_count` = 0).
- **Generator contract:** the generator starts a frame only when `gen_enable` was high in the preceding cycle. A frame is at least 72 cycles, so dropping `gen_enable` on the Nth `sof` always precedes the next frame start.

## Timing
- **Reset values:** all outputs 0; state IDLE; all counters 0. Reset mid-operation forces `gen_enable` low on the next edge with no `done` pulse.
- **Start latency:** start sampled at edge k; `gen_enable` and `busy` are high after edge k. An empty start pulses `done` after edge k with `busy` staying 0.
- **Burst end:** Nth `sof` sampled at edge t; `gen_enable` is low after edge t, and `frames_total` is updated after edge t.
- **Gap:** first `gmii_en` = 0 sampled at edge d; `gen_enable` returns high after edge d+`gap_cycles`, giving exactly `gap_cycles` GAP cycles. With `gap_cycles` = 0, it returns high after edge d.
- **done:** asserted for exactly the cycle following the terminating edge; `busy` falls on the same edge.

## Test plan
- **Normal schedule:** generator model (72-cycle frames, 12-cycle IFG while enabled); `burst_frames`=3, `burst_count`=2, `gap_cycles`=100 -> 6 sofs; gap between the 3rd frame's end and the 4th `sof` ≥ 100 cycles; `bursts_done`=2; `frames_total`=6; one `done` pulse.
- **Zero gap and infinite mode:** `gap_cycles`=0, `burst_count`=0, `burst_frames`=4 -> `gen_enable` re-asserts the cycle after `gmii_en` falls. After 1000 cycles, stop -> `done` pulse; `frames_total` mod 4 may be nonzero; `bursts_done` = floor(`frames_total`/4).
- **Stop during GAP:** `gap_cycles`=500, stop 10 cycles into GAP -> `busy` low and `done` high on the next cycle; no further `sof`.
- **Degenerate start:** `burst_frames`=0 -> `done` pulse one cycle after start; `gen_enable` never high; counters 0.
- **Start edge cases:**
  - start while `gmii_en` already high (frame in flight) -> that frame is not counted.
  - Repeated start while busy -> ignored; latched config unchanged.
- **Reset mid-burst:** `rst` asserted in RUN -> all outputs 0 after the edge; a subsequent start behaves as from power-up.
